// File: rtl/io_dma_pkg.sv
// Shared types and constants for the I/O DMA master: FSM state encoding,
// word size and the address bit that selects I/O space over data memory.
package io_dma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } dma_state_e;

  localparam int unsigned WORD_BYTES   = 4;
  localparam int unsigned IO_SPACE_BIT = 7;

  localparam logic [31:0] ALIGN_MASK = ~32'(WORD_BYTES - 1);

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/io_dma_addr_gen.sv
// Source/destination word pointers and remaining-word counter for the DMA
// master; load captures a new transfer, step retires one word.
module io_dma_addr_gen
  import io_dma_pkg::*;
#(
  parameter int unsigned LEN_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [31:0]      src_in,
  input  logic [31:0]      dst_in,
  input  logic [LEN_W-1:0] len_in,
  output logic [31:0]      src_ptr,
  output logic [31:0]      dst_ptr,
  output logic             last
);

  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    if (load) begin
      src_d = word_align(src_in);
      dst_d = word_align(dst_in);
      cnt_d = len_in;
    end else if (step) begin
      // 32-bit adds wrap through the top of the address space silently
      src_d = src_q + 32'(WORD_BYTES);
      dst_d = dst_q + 32'(WORD_BYTES);
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
    end
  end

  assign src_ptr = src_q;
  assign dst_ptr = dst_q;
  assign last    = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/io_dma_master.sv
// Word-copy DMA master: READ/WRITE ping-pong over a single bus port.
// Optional constant-fill mode is built in when IO_DMA_FILL_EN is defined.
module io_dma_master
  import io_dma_pkg::*;
#(
  parameter int unsigned LEN_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
`ifdef IO_DMA_FILL_EN
  input  logic             fill,
  input  logic [31:0]      fill_value,
`endif
  output logic [31:0]      addr,
  output logic [31:0]      datain,
  output logic             we,
  input  logic [31:0]      dataout,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  dma_state_e  state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic        aborted_q, aborted_d;
  logic        load, step, last;
  logic [31:0] src_ptr, dst_ptr;
  logic        fill_now, fill_active;
  logic [31:0] fill_word;

`ifdef IO_DMA_FILL_EN
  logic        fill_q, fill_d;
  logic [31:0] fill_value_q, fill_value_d;

  always_comb begin
    fill_d       = fill_q;
    fill_value_d = fill_value_q;
    if (state_q == IDLE && start) begin
      fill_d       = fill;
      fill_value_d = fill_value;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fill_q       <= 1'b0;
      fill_value_q <= '0;
    end else begin
      fill_q       <= fill_d;
      fill_value_q <= fill_value_d;
    end
  end

  assign fill_now    = fill;
  assign fill_active = fill_q;
  assign fill_word   = fill_value_q;
`else
  assign fill_now    = 1'b0;
  assign fill_active = 1'b0;
  assign fill_word   = '0;
`endif

  io_dma_addr_gen #(
    .LEN_W (LEN_W)
  ) u_addr_gen (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .src_in  (src_addr),
    .dst_in  (dst_addr),
    .len_in  (len),
    .src_ptr (src_ptr),
    .dst_ptr (dst_ptr),
    .last    (last)
  );

  // Next-state, pointer control and holding-register capture
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    aborted_d = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            load    = 1'b1;
            state_d = fill_now ? WRITE : READ;
          end else begin
            state_d = FINISH;
          end
        end
      end
      READ: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          hold_d  = dataout;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          step    = 1'b1;
          state_d = last ? FINISH : (fill_active ? WRITE : READ);
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      aborted_q <= aborted_d;
    end
  end

  // Bus outputs decode from state; abort and reset gate we in the same cycle
  always_comb begin
    addr    = '0;
    datain  = '0;
    we      = 1'b0;
    busy    = 1'b0;
    done    = (state_q == FINISH);
    aborted = aborted_q;
    unique case (state_q)
      READ: begin
        busy = 1'b1;
        addr = src_ptr;
      end
      WRITE: begin
        busy   = 1'b1;
        addr   = dst_ptr;
        datain = fill_active ? fill_word : hold_q;
        we     = ~abort & ~reset;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_io_dma_master.sv
// Randomized self-checking bench for io_dma_master against a per-word
// transfer model (build with IO_DMA_FILL_EN to exercise fill mode).
module tb_io_dma_master;
  import io_dma_pkg::*;

  localparam int unsigned LEN_W = 6;

  logic             clock;
  logic             reset;
  logic             start;
  logic             abort;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic [31:0]      addr;
  logic [31:0]      datain;
  logic             we;
  logic [31:0]      dataout;
  logic             busy;
  logic             done;
  logic             aborted;
`ifdef IO_DMA_FILL_EN
  logic             fill;
  logic [31:0]      fill_value;
`endif

  logic [31:0] mem [256];
  int total;
  int bad;

  io_dma_master #(
    .LEN_W (LEN_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
`ifdef IO_DMA_FILL_EN
    .fill       (fill),
    .fill_value (fill_value),
`endif
    .addr       (addr),
    .datain     (datain),
    .we         (we),
    .dataout    (dataout),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  assign dataout = mem_at(addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transfer: model expectations, drive it cycle by cycle, compare.
  // abort_at/reset_at/restart_at are cycle numbers after start (0 = unused).
  task automatic run_xfer(input string name, input int n, input logic [31:0] src,
                          input logic [31:0] dst, input bit fill_m, input logic [31:0] fval,
                          input int abort_at, input int reset_at, input int restart_at);
    logic [31:0] ew_a[$], ew_d[$], er_a[$], ow_a[$], ow_d[$], or_a[$];
    int ew_c[$], ow_c[$];
    int stop, ncyc, exp_done, exp_ab;
    int done_cyc, done_cnt, ab_cyc, ab_cnt, busy_cnt, post_rst, idle_bad;
    logic [31:0] s_al, d_al;

    s_al = src & 32'hFFFF_FFFC;
    d_al = dst & 32'hFFFF_FFFC;
    stop = 1000000;
    if (abort_at > 0) stop = abort_at;
    if (reset_at > 0 && reset_at < stop) stop = reset_at;
    for (int i = 0; i < n; i++) begin
      int wc;
      wc = fill_m ? i + 1 : 2 * (i + 1);
      if (!fill_m && (2 * i + 1) < stop) er_a.push_back(s_al + 32'(4 * i));
      if (wc < stop) begin
        ew_a.push_back(d_al + 32'(4 * i));
        ew_d.push_back(fill_m ? fval : mem_at(s_al + 32'(4 * i)));
        ew_c.push_back(wc);
      end
    end
    exp_done = (stop == 1000000) ? (fill_m ? n + 1 : 2 * n + 1) : -1;
    exp_ab   = (abort_at > 0) ? abort_at + 1 : -1;
    ncyc     = (fill_m ? n : 2 * n) + 4;

    done_cyc = -1; done_cnt = 0; ab_cyc = -1; ab_cnt = 0;
    busy_cnt = 0; post_rst = 0; idle_bad = 0;

    @(negedge clock);
    start    = 1'b1;
    src_addr = src;
    dst_addr = dst;
    len      = LEN_W'(n);
`ifdef IO_DMA_FILL_EN
    fill       = fill_m;
    fill_value = fval;
`endif
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      start = (k == restart_at);
      if (k == restart_at) begin
        src_addr = $urandom;
        dst_addr = $urandom;
        len      = LEN_W'($urandom_range(1, 63));
      end
      abort = (k == abort_at);
      reset = (k == reset_at);
      #1;
      if (we) begin
        ow_a.push_back(addr);
        ow_d.push_back(datain);
        ow_c.push_back(k);
      end else if (busy && !abort && !reset) begin
        or_a.push_back(addr);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (aborted) begin
        ab_cnt++;
        if (ab_cyc < 0) ab_cyc = k;
      end
      if (busy) busy_cnt++;
      if (reset_at > 0 && k > reset_at && (busy || we)) post_rst++;
      if (!busy && (we || addr != 32'h0 || datain != 32'h0)) idle_bad++;
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;

    check_eq({name, ".nwr"}, 32'(ow_a.size()), 32'(ew_a.size()));
    for (int i = 0; i < ew_a.size() && i < ow_a.size(); i++) begin
      check_eq({name, ".wr_addr"}, ow_a[i], ew_a[i]);
      check_eq({name, ".wr_data"}, ow_d[i], ew_d[i]);
      check_eq({name, ".wr_cyc"}, 32'(ow_c[i]), 32'(ew_c[i]));
    end
    check_eq({name, ".nrd"}, 32'(or_a.size()), 32'(er_a.size()));
    for (int i = 0; i < er_a.size() && i < or_a.size(); i++)
      check_eq({name, ".rd_addr"}, or_a[i], er_a[i]);
    check_eq({name, ".done_cyc"}, 32'(done_cyc), 32'(exp_done));
    check_eq({name, ".done_cnt"}, 32'(done_cnt), (exp_done >= 0) ? 32'd1 : 32'd0);
    check_eq({name, ".abort_cyc"}, 32'(ab_cyc), 32'(exp_ab));
    check_eq({name, ".abort_cnt"}, 32'(ab_cnt), (exp_ab >= 0) ? 32'd1 : 32'd0);
    check_eq({name, ".idle_outputs"}, 32'(idle_bad), 32'd0);
    if (reset_at > 0) check_eq({name, ".post_reset_busy"}, 32'(post_rst), 32'd0);
    if (n == 0) check_eq({name, ".len0_busy"}, 32'(busy_cnt), 32'd0);
  endtask

  initial begin
    int n, ab;
    logic [31:0] s, d;

    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
`ifdef IO_DMA_FILL_EN
    fill = 1'b0; fill_value = '0;
`endif
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check_eq("rst.we", 32'(we), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.aborted", 32'(aborted), 32'd0);
    check_eq("rst.addr", addr, 32'h0);

    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    run_xfer("copy3", 3, 32'h0, 32'h80, 1'b0, 32'h0, 0, 0, 0);
    run_xfer("len0", 0, 32'h40, 32'h80, 1'b0, 32'h0, 0, 0, 0);
    run_xfer("abort_w2", 4, 32'h10, 32'h90, 1'b0, 32'h0, 4, 0, 0);
    run_xfer("wrap", 2, 32'hFFFF_FFFC, 32'h100, 1'b0, 32'h0, 0, 0, 0);
    run_xfer("restart", 4, 32'h20, 32'hA0, 1'b0, 32'h0, 0, 0, 2);
    run_xfer("mid_reset", 4, 32'h30, 32'hC0, 1'b0, 32'h0, 0, 3, 0);
    run_xfer("abort_rd", 3, 32'h44, 32'hD3, 1'b0, 32'h0, 3, 0, 0);
    run_xfer("unaligned", 2, 32'h0000_0207, 32'h0000_0382, 1'b0, 32'h0, 0, 0, 0);

    for (int t = 0; t < 24; t++) begin
      n  = $urandom_range(0, 12);
      s  = $urandom;
      d  = $urandom | (32'h1 << IO_SPACE_BIT);
      ab = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * n) : 0;
      run_xfer("rand", n, s, d, 1'b0, 32'h0, ab, 0, 0);
    end
    run_xfer("max_len", 63, $urandom, $urandom, 1'b0, 32'h0, 0, 0, 0);

`ifdef IO_DMA_FILL_EN
    run_xfer("fill3", 3, 32'h0, 32'h80, 1'b1, 32'hA5A5_A5A5, 0, 0, 0);
    run_xfer("fill_abort", 5, 32'h0, 32'h200, 1'b1, 32'h5A5A_0001, 3, 0, 0);
    run_xfer("fill0", 0, 32'h0, 32'h200, 1'b1, 32'h1234_5678, 0, 0, 0);
    for (int t = 0; t < 6; t++)
      run_xfer("fill_rand", $urandom_range(1, 12), $urandom, $urandom, 1'b1, $urandom, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_dma_master.md
IO_DMA_MASTER -- requirements
Module: io_dma_master

Interface
REQ-001 The block SHALL have one parameter, LEN_W, default 6, which is the width of the word-count input (maximum 63 words).
REQ-002 The block SHALL have port clock, input, 1 bit: the sole clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle transfer request, sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: cancels an active transfer.
REQ-006 The block SHALL have port src_addr, input, 32 bits: source byte address.
REQ-007 The block SHALL have port dst_addr, input, 32 bits: destination byte address.
REQ-008 The block SHALL have port len, input, LEN_W bits: number of words to transfer.
REQ-009 The block SHALL have port addr, output, 32 bits: bus byte address, word-aligned (bits [1:0] = 0).
REQ-010 The block SHALL have port datain, output, 32 bits: bus write data.
REQ-011 The block SHALL have port we, output, 1 bit: bus write enable.
REQ-012 The block SHALL have port dataout, input, 32 bits: bus read data, valid in the same cycle that addr is presented.
REQ-013 The block SHALL have port busy, output, 1 bit: high in the READ and WRITE states.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.
REQ-015 The block SHALL have port aborted, output, 1 bit: one-cycle pulse when a transfer is cancelled.

Function
REQ-016 The block SHALL use the FSM states IDLE, READ, WRITE and FINISH.
REQ-017 IDLE with start=1 and len!=0 SHALL latch src_addr, dst_addr (each with bits [1:0] cleared) and len, then go to READ.
REQ-018 IDLE with start=1 and len=0 SHALL go to FINISH without issuing any bus cycle.
REQ-019 READ SHALL drive addr=src pointer with we=0, capture dataout into a 32-bit holding register at the clock edge, and go to WRITE.
REQ-020 WRITE SHALL drive addr=dst pointer, datain=holding register and we=1 for exactly one cycle, then decrement the remaining count and advance both pointers by 4.
REQ-021 From WRITE, the block SHALL go to FINISH if the remaining count reaches 0, otherwise to READ.
REQ-022 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-023 Throughput SHALL be 2 cycles per word, and done SHALL assert 2*len+1 cycles after the start cycle.
REQ-024 Pointer increments SHALL wrap modulo 2^32 with no error flag.
REQ-025 abort in READ or WRITE SHALL force we=0 in that same cycle (combinationally), pulse aborted next cycle, and return to IDLE without pulsing done.
REQ-026 abort in IDLE or FINISH SHALL be ignored.
REQ-027 start while busy SHALL be ignored, and the latched parameters SHALL be unaffected.
REQ-028 If start and abort are both high in IDLE, start SHALL win.
REQ-029 Outside WRITE, we SHALL be 0 and datain SHALL be 0.
REQ-030 In IDLE and FINISH, addr SHALL be 0.

Reset
REQ-031 Reset SHALL put the FSM in IDLE and clear both pointers, the count and the holding register.
REQ-032 In the cycle after reset, we, busy, done and aborted SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL suppress we in the cycle it is sampled high, and neither done nor aborted SHALL pulse.

Configuration
REQ-034 The block SHALL support one optional fill feature controlled by the macro IO_DMA_FILL_EN.
REQ-035 With IO_DMA_FILL_EN defined, the block SHALL add input fill (1 bit) and fill_value (32 bits), both latched at start.
REQ-036 With IO_DMA_FILL_EN defined and fill latched as 1, READ SHALL be skipped, every WRITE SHALL use fill_value, and the rate SHALL be 1 word/cycle, with done asserting len+1 cycles after start.
REQ-037 Without IO_DMA_FILL_EN, the fill and fill_value ports SHALL be absent and the block SHALL copy only.

Structure
REQ-038 A package io_dma_pkg SHALL hold the FSM state typedef, WORD_BYTES=4, and IO_SPACE_BIT=7 (the address bit selecting I/O space over data memory).
REQ-039 One sub-module, io_dma_addr_gen, SHALL hold the src/dst pointers and remaining counter, with load and step controls and a last-word flag.

Verification
REQ-040 Bench scenario: src=0x00, dst=0x80, len=3, memory words 0x11/0x22/0x33 -> writes to 0x80, 0x84, 0x88 with those values, done at cycle 7.
REQ-041 Bench scenario: start with len=0 -> no we, done 1 cycle after start, busy never high.
REQ-042 Bench scenario: len=4, abort during the second WRITE -> exactly 1 completed write, we low in the abort cycle, aborted pulses once, done never asserts.
REQ-043 Bench scenario: src=0xFFFFFFFC, len=2 -> second read at 0x00000000.
REQ-044 Bench scenario: start pulsed again at cycle 2 of an active transfer, and reset at cycle 3 of another transfer -> the second start is ignored, and after reset busy=0, we=0, with no done.
REQ-045 Bench scenario (IO_DMA_FILL_EN defined): fill=1, fill_value=0xA5A5A5A5, dst=0x80, len=3 -> three consecutive write cycles at 0x80/0x84/0x88, done at cycle 4.
